mailbox_fifo: RTL
=================

# mailbox_fifo

Register-mapped FIFO mailbox peripheral that responds to the host register bus (read/write strobes, 2-bit word address, 32-bit data, one-cycle read-valid). The host pushes words by writing the DATA register and pops them by reading it. Occupancy, overflow and underflow are reported in STATUS, and a level interrupt fires on programmable conditions. It sits beside the existing counter peripheral in the host address map.

## Interface
- DEPTH, 16, FIFO entries; power of two, 2..256
- DATA_WIDTH, 32, FIFO word width; ≤ 32, zero-extended on read
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high reset
- reg_read  input  1  read strobe, one cycle per access
- reg_write  input  1  write strobe, one cycle per access
- reg_address  input  2  word address: 0 DATA, 1 CONFIG, 2 STATUS, 3 reserved
- reg_data_in  input  32  write data
- reg_read_valid  output  1  read data valid, one cycle
- reg_data_out  output  32  read data; 0 whenever reg_read_valid is low
- irq  output  1  registered level interrupt

## Operation
- Storage: DEPTH x DATA_WIDTH array, with read and write pointers of width log2(DEPTH) that wrap modulo DEPTH. count is log2(DEPTH)+1 bits wide, range 0..DEPTH.
- CONFIG, read/write:
  - bit0 EN
  - bit1 IE_NEMPTY
  - bit2 IE_THRESH
  - bit3 IE_ERR
  - bit4 FLUSH: write-only, self-clearing, reads 0
  - bits[16:8] THRESH
  - all other bits read 0
- FLUSH=1 zeroes the pointers and count in the same edge as the CONFIG write. Array contents are not cleared. The other CONFIG bits update from the same write.
- STATUS, read-only except the W1C bits:
  - bits[8:0] count
  - bit9 EMPTY
  - bit10 FULL
  - bit11 OVF (sticky)
  - bit12 UDF (sticky)
  - Writing 1 to bit11 or bit12 clears that bit. A set event in the same cycle wins over the clear.
- Write to DATA:
  - EN=1, not full: store reg_data_in[DATA_WIDTH-1:0] at the write pointer; advance the pointer; count+1.
  - EN=1, full: drop the word and set OVF. Pointers and count unchanged.
  - EN=0: drop the word. No flag is set.
- Read from DATA:
  - EN=1, not empty: return the head entry; advance the read pointer; count-1.
  - EN=1, empty: return 0 and set UDF.
  - EN=0: return 0. No pop, no flag.
- Reserved address: reads return 0; writes are ignored.
- If reg_read and reg_write are both high in one cycle, the read is performed and the write is ignored.
- irq (registered) is the OR of:
  - IE_NEMPTY & !EMPTY
  - IE_THRESH & (count ≥ THRESH)
  - IE_ERR & (OVF | UDF)
- Reset values:
  - CONFIG = 0, pointers = 0, count = 0, OVF = UDF = 0
  - reg_read_valid = 0, reg_data_out = 0, irq = 0
  - Reset asserted mid-access aborts the access; no read_valid follows.

## Timing
- Read: strobe sampled at edge N. reg_read_valid = 1 and reg_data_out valid from edge N+1 until edge N+2, then both return to 0.
- Back-to-back reads on consecutive cycles each get their own valid cycle, in order.
- Write: takes effect at the sampling edge N. A read issued in cycle N+1 already reflects it.
- STATUS read data is the state after all edges up to and including the read's sampling edge. The pop and UDF caused by that same read do not appear in the returned value.
- irq updates one edge after the state change that causes it, e.g. push at edge N → irq at edge N+1.
- Pointer wrap: after DEPTH pushes and DEPTH pops, both pointers are back at 0 and ordering is preserved.
- Throughput: one access per cycle, no wait states, no backpressure.

## Test plan
1. **Reset:** after the reset pulse, STATUS = 0x200 (EMPTY), CONFIG = 0, irq = 0, reg_read_valid = 0.
2. **Fill to full:**
   - Stimulus: CONFIG = 0x1; push 1..16; push 99.
   - STATUS = 0xC10 (count 16, FULL, OVF).
   - 16 pops return 1..16 in order.
   - Next pop returns 0 and sets UDF (STATUS = 0x1A00).
3. **W1C clear and clear-vs-set:** write STATUS = 0x1800 → OVF and UDF clear. Write STATUS = 0x1000 in the same cycle as a pop from empty → UDF stays 1.
4. **Wrap-around:**
   - Stimulus: push/pop 10 words, then push 0xA0..0xAF.
   - Pops return 0xA0..0xAF in order; count returns to 0.
5. **Interrupts:**
   - CONFIG = 0x0305 (EN, IE_THRESH, THRESH = 3): irq rises exactly one cycle after the 3rd push and falls one cycle after the pop that leaves count = 2.
   - IE_ERR with overflow raises irq until OVF is cleared.
6. **Disable and flush:**
   - With EN=0, a DATA write followed by a DATA read leaves count and flags unchanged and the read returns 0.
   - With EN=1, push 5 words, then write CONFIG = 0x11 (EN + FLUSH): STATUS count = 0 and EMPTY = 1 on the next read, and CONFIG reads back 0x1.

Source files
------------

// File: rtl/mailbox_fifo.sv
// mailbox_fifo
// Register-mapped FIFO mailbox. The host pushes words by writing DATA and pops
// them by reading DATA. Occupancy and sticky overflow/underflow flags appear in
// STATUS, and a registered level interrupt is raised on programmable conditions.
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous, active-high reset
//   reg_read        read strobe, one cycle per access
//   reg_write       write strobe, one cycle per access
//   reg_address     word address: 0 DATA, 1 CONFIG, 2 STATUS, 3 reserved
//   reg_data_in     write data
//   reg_read_valid  one-cycle read-data qualifier
//   reg_data_out    read data, zero whenever reg_read_valid is low
//   irq             registered level interrupt
//
// Register map
//   CONFIG: [0] EN, [1] IE_NEMPTY, [2] IE_THRESH, [3] IE_ERR,
//           [4] FLUSH (write-only, self-clearing), [16:8] THRESH
//   STATUS: [8:0] count, [9] EMPTY, [10] FULL, [11] OVF (W1C), [12] UDF (W1C)

module mailbox_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_read,
    input  logic        reg_write,
    input  logic [1:0]  reg_address,
    input  logic [31:0] reg_data_in,
    output logic        reg_read_valid,
    output logic [31:0] reg_data_out,
    output logic        irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CONFIG = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    // Storage and pointers
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    // Configuration and sticky flags
    logic       cfg_en;
    logic       cfg_ie_nempty;
    logic       cfg_ie_thresh;
    logic       cfg_ie_err;
    logic [8:0] cfg_thresh;
    logic       ovf;
    logic       udf;

    // Two-stage read return: stage 1 captures the word at the sampling edge,
    // stage 2 presents it on the bus one edge later.
    logic        rd_pend;
    logic [31:0] rd_hold;

    // Bus decode; a read wins over a simultaneous write.
    logic do_read;
    logic do_write;
    logic data_rd;
    logic data_wr;
    logic cfg_wr;
    logic stat_wr;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic ovf_set;
    logic udf_set;
    logic flush;

    logic [31:0] config_word;
    logic [31:0] status_word;
    logic [31:0] rd_word;
    logic        irq_next;

    logic unused_data_in;

    assign do_read  = reg_read;
    assign do_write = reg_write & ~reg_read;

    assign data_rd = do_read  & (reg_address == ADDR_DATA);
    assign data_wr = do_write & (reg_address == ADDR_DATA);
    assign cfg_wr  = do_write & (reg_address == ADDR_CONFIG);
    assign stat_wr = do_write & (reg_address == ADDR_STATUS);

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    assign push    = data_wr & cfg_en & ~full;
    assign ovf_set = data_wr & cfg_en &  full;
    assign pop     = data_rd & cfg_en & ~empty;
    assign udf_set = data_rd & cfg_en &  empty;
    assign flush   = cfg_wr & reg_data_in[4];

    // Bits that only matter for narrower DATA_WIDTH or are reserved in CONFIG.
    assign unused_data_in = ^{reg_data_in[31:17], reg_data_in[7:5]};

    assign config_word = {15'b0, cfg_thresh, 4'b0,
                          cfg_ie_err, cfg_ie_thresh, cfg_ie_nempty, cfg_en};

    assign status_word = {19'b0, udf, ovf, full, empty, 9'(count)};

    // Read data is formed from the pre-edge state, so the pop or UDF caused by
    // this same read never shows up in the value returned.
    always_comb begin
        rd_word = 32'b0;
        case (reg_address)
            ADDR_DATA: begin
                if (cfg_en && !empty) begin
                    rd_word = 32'(mem[rd_ptr]);
                end
            end
            ADDR_CONFIG: rd_word = config_word;
            ADDR_STATUS: rd_word = status_word;
            default:     rd_word = 32'b0;
        endcase
    end

    // irq is registered from the current state, so it trails the causing
    // state change by exactly one edge.
    assign irq_next = (cfg_ie_nempty & ~empty) |
                      (cfg_ie_thresh & (9'(count) >= cfg_thresh)) |
                      (cfg_ie_err & (ovf | udf));

    // FIFO array carries no reset; flush only moves the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= reg_data_in[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                count  <= count + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                count  <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_en        <= 1'b0;
            cfg_ie_nempty <= 1'b0;
            cfg_ie_thresh <= 1'b0;
            cfg_ie_err    <= 1'b0;
            cfg_thresh    <= 9'b0;
        end else if (cfg_wr) begin
            cfg_en        <= reg_data_in[0];
            cfg_ie_nempty <= reg_data_in[1];
            cfg_ie_thresh <= reg_data_in[2];
            cfg_ie_err    <= reg_data_in[3];
            cfg_thresh    <= reg_data_in[16:8];
        end
    end

    // Sticky flags: a set event in the same cycle beats a W1C clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (stat_wr && reg_data_in[11]) begin
                ovf <= 1'b0;
            end
            if (udf_set) begin
                udf <= 1'b1;
            end else if (stat_wr && reg_data_in[12]) begin
                udf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend        <= 1'b0;
            rd_hold        <= 32'b0;
            reg_read_valid <= 1'b0;
            reg_data_out   <= 32'b0;
        end else begin
            rd_pend        <= do_read;
            rd_hold        <= do_read ? rd_word : 32'b0;
            reg_read_valid <= rd_pend;
            reg_data_out   <= rd_pend ? rd_hold : 32'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_next;
        end
    end

endmodule
